// File: rtl/step_move_ctrl.sv
// ---------------------------------------------------------------------------
// step_move_ctrl
//
// Purpose: issues a move of N steps to a stepper phase sequencer. A move is
// requested with a start pulse. The block then produces one step_clk rising
// edge per step period, holds en and busy high for the whole move, and pulses
// done for one clock when the move ends, either normally or through stop.
//
// FSM: IDLE -> RUN -> FINISH -> IDLE. All outputs are registered.
//
// Optional feature, controlled by macro STEP_MOVE_RAMP_EN:
//   When defined, the effective period of the first step is 2*period. Each
//   later step shortens it by max(period>>4, 1), down to a floor of period.
//   When undefined, every step uses period and the ramp logic is not built.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   move request (accepted in IDLE only)
//   dir_cmd  in   direction, latched on an accepted start
//   steps    in   [STEP_W] step count, latched on an accepted start
//   period   in   [CNT_W] clk cycles per step, latched on an accepted start
//   stop     in   abort request, honoured at the end of the current step
//   step_clk out  step-rate clock, one rising edge per step
//   en       out  motor enable, high for the whole move
//   dir      out  latched direction, held until the next accepted start
//   busy     out  high in any state other than IDLE
//   done     out  one-clock pulse when a move ends
//
// Handshake: start is a level, sampled every clock. It is consumed only in
// IDLE with steps != 0 and period >= 2. Any other start is dropped without a
// response.
// ---------------------------------------------------------------------------
module step_move_ctrl #(
   parameter int CNT_W  = 24,
   parameter int STEP_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dir_cmd,
   input  logic [STEP_W-1:0] steps,
   input  logic [CNT_W-1:0]  period,
   input  logic              stop,
   output logic              step_clk,
   output logic              en,
   output logic              dir,
   output logic              busy,
   output logic              done
);

`ifdef STEP_MOVE_RAMP_EN
   // The ramped period can reach 2*period, so one extra bit is needed.
   localparam int PW = CNT_W + 1;
`else
   localparam int PW = CNT_W;
`endif

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;

   logic [PW-1:0]     r_cnt;
   logic [STEP_W-1:0] r_rem;
   logic [CNT_W-1:0]  r_period;
   logic              r_stop_req;
   logic              r_dir;
   logic              r_step_clk;
   logic              r_en;
   logic              r_busy;
   logic              r_done;

   logic [PW-1:0]     w_p;
   logic              w_accept;
   logic              w_wrap;
   logic              w_end;
   logic              w_step_clk_nxt;
   logic              w_active_nxt;
   logic              w_done_nxt;

`ifdef STEP_MOVE_RAMP_EN
   logic [PW-1:0]     r_p;
   logic [PW-1:0]     w_ramp_dec;
   logic [PW-1:0]     w_p_dec;
   logic [PW-1:0]     w_p_next;

   assign w_p        = r_p;
   assign w_ramp_dec = (r_period[CNT_W-1:4] == '0) ? PW'(1) : PW'(r_period >> 4);
   assign w_p_dec    = r_p - w_ramp_dec;
   // r_p never drops below r_period, so the subtraction cannot wrap.
   assign w_p_next   = (w_p_dec < PW'(r_period)) ? PW'(r_period) : w_p_dec;
`else
   assign w_p = r_period;
`endif

   // period < 2 means no bit above bit 0 is set.
   assign w_accept = (r_state == S_IDLE) && start && (steps != '0) &&
                     (period[CNT_W-1:1] != '0);
   assign w_wrap   = (r_state == S_RUN) && (r_cnt == w_p - PW'(1));
   // A stop seen on the wrap edge itself ends the move on that same wrap.
   assign w_end    = w_wrap && ((r_rem == STEP_W'(1)) || r_stop_req || stop);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next_state = S_RUN;
         S_RUN:    if (w_end)    w_next_state = S_FINISH;
         S_FINISH: w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Output logic. This computes next-cycle output values, which the output
   // register below captures. step_clk reflects the counter value from the
   // previous cycle, so the first rising edge lands one clock after en rises.
   always_comb begin
      w_active_nxt   = 1'b0;
      w_done_nxt     = 1'b0;
      w_step_clk_nxt = 1'b0;
      case (w_next_state)
         S_RUN: begin
            w_active_nxt   = 1'b1;
            w_step_clk_nxt = (r_state == S_RUN) && (r_cnt < (w_p >> 1));
         end
         S_FINISH: begin
            w_active_nxt = 1'b1;
            w_done_nxt   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step_clk <= 1'b0;
         r_en       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_step_clk <= w_step_clk_nxt;
         r_en       <= w_active_nxt;
         r_busy     <= w_active_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Datapath: latched command, period counter, remaining steps
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_rem      <= '0;
         r_period   <= '0;
         r_stop_req <= 1'b0;
         r_dir      <= 1'b0;
`ifdef STEP_MOVE_RAMP_EN
         r_p        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cnt      <= '0;
                  r_rem      <= steps;
                  r_period   <= period;
                  r_stop_req <= 1'b0;
                  r_dir      <= dir_cmd;
`ifdef STEP_MOVE_RAMP_EN
                  r_p        <= {period, 1'b0};
`endif
               end
            end
            S_RUN: begin
               // Remember stop until the current step period completes.
               if (stop) r_stop_req <= 1'b1;
               if (w_wrap) begin
                  r_cnt <= '0;
                  r_rem <= r_rem - STEP_W'(1);
`ifdef STEP_MOVE_RAMP_EN
                  r_p   <= w_p_next;
`endif
               end else begin
                  r_cnt <= r_cnt + PW'(1);
               end
            end
            default: begin
               r_cnt      <= '0;
               r_rem      <= '0;
               r_stop_req <= 1'b0;
            end
         endcase
      end
   end

   assign step_clk = r_step_clk;
   assign en       = r_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign dir      = r_dir;

endmodule

// File: tb/tb_step_move_ctrl.sv
// ---------------------------------------------------------------------------
// tb_step_move_ctrl
//
// Self-checking bench for step_move_ctrl. It applies directed moves, measures
// en length, step_clk edges and done pulses, and compares each result with a
// hand-computed value through the check task.
//
// Sample timing: inputs are driven and outputs sampled on the falling edge.
// Sample t=0 is the cycle right after the accepting rising edge.
// ---------------------------------------------------------------------------
module tb_step_move_ctrl;

   logic        clk;
   logic        rst;
   logic        start;
   logic        dir_cmd;
   logic [15:0] steps;
   logic [23:0] period;
   logic        stop;
   logic        step_clk;
   logic        en;
   logic        dir;
   logic        busy;
   logic        done;

   int n_cmp;
   int n_bad;

   // Per-move measurements
   int m_en;
   int m_high;
   int m_done;
   int m_done_t;
   int m_dir_bad;
   int m_timeout;
   int rise_q[$];

   step_move_ctrl #(.CNT_W(24), .STEP_W(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dir_cmd  (dir_cmd),
      .steps    (steps),
      .period   (period),
      .stop     (stop),
      .step_clk (step_clk),
      .en       (en),
      .dir      (dir),
      .busy     (busy),
      .done     (done)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int rq(input int i);
      if (i < rise_q.size()) return rise_q[i];
      return -1;
   endfunction

   // Drives one start and follows the move until busy falls.
   //   stop_rise : assert stop for one cycle at this step_clk rise (0 = never)
   //   inj_t     : sample at which a second, different start is driven (-1 = never)
   //   rst_t     : sample at which rst is asserted mid-move (-1 = never)
   //   stop_go   : hold stop high together with the start
   task automatic run_move(input logic d, input int n, input int p, input int stop_rise,
                           input int inj_t, input int rst_t, input logic stop_go,
                           input int max_cyc);
      logic prev_sc;
      m_en = 0; m_high = 0; m_done = 0; m_done_t = -1; m_dir_bad = 0; m_timeout = 0;
      rise_q.delete();
      @(negedge clk);
      dir_cmd = d; steps = 16'(n); period = 24'(p); start = 1'b1; stop = stop_go;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      prev_sc = 1'b0;
      for (int t = 0; t <= max_cyc; t++) begin
         if (t > 0) @(negedge clk);
         start = 1'b0; stop = 1'b0;
         if (t == max_cyc) begin
            m_timeout = 1;
            break;
         end
         if (!busy) break;
         if (en) m_en++;
         if (step_clk) m_high++;
         if (step_clk && !prev_sc) begin
            rise_q.push_back(t);
            if (rise_q.size() == stop_rise) stop = 1'b1;
         end
         prev_sc = step_clk;
         if (done) begin
            m_done++;
            m_done_t = t;
         end
         if (dir !== d) m_dir_bad++;
         if (t == inj_t) begin
            start = 1'b1; dir_cmd = ~d; steps = 16'd7; period = 24'd3;
         end
         if (t == rst_t) begin
            rst = 1'b1;
            #1;
            check("rst_async_outputs", int'({step_clk, en, busy, done, dir}), 0);
            break;
         end
      end
   endtask

   // A start that must be dropped: watch a few cycles for any activity.
   task automatic idle_probe(input string tag, input int n, input int p);
      int act;
      act = 0;
      @(negedge clk);
      steps = 16'(n); period = 24'(p); dir_cmd = 1'b1; start = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (busy || en || done) act++;
      end
      start = 1'b0;
      check(tag, act, 0);
   endtask

   task automatic check_idle_after(input string tag, input logic d);
      check({tag, "_busy_after"}, int'(busy), 0);
      check({tag, "_en_after"}, int'(en), 0);
      check({tag, "_done_after"}, int'(done), 0);
      check({tag, "_dir_held"}, int'(dir), int'(d));
      check({tag, "_timeout"}, m_timeout, 0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1; start = 1'b0; dir_cmd = 1'b0; steps = '0; period = '0; stop = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", int'({step_clk, en, busy, done, dir}), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", int'({step_clk, en, busy, done, dir}), 0);

      // Dropped starts, including stop alone in IDLE
      idle_probe("ignore_steps0", 0, 10);
      idle_probe("ignore_period1", 5, 1);
      idle_probe("ignore_period0", 5, 0);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("stop_in_idle", int'({en, busy, done}), 0);

`ifdef STEP_MOVE_RAMP_EN
      // Ramped move: 32, 31, ... 17, then 16 from step 17 onward
      run_move(1'b0, 20, 16, 0, -1, -1, 1'b0, 1000);
      check("ramp_rises", rise_q.size(), 20);
      check("ramp_first_rise", rq(0), 1);
      check("ramp_step1", rq(1) - rq(0), 32);
      check("ramp_step2", rq(2) - rq(1), 31);
      check("ramp_step16", rq(16) - rq(15), 17);
      check("ramp_step17", rq(17) - rq(16), 16);
      check("ramp_step19", rq(19) - rq(18), 16);
      check("ramp_en_len", m_en, 457);
      check("ramp_done", m_done, 1);
      check_idle_after("ramp", 1'b0);
`else
      // Basic move: period 10, 3 steps
      run_move(1'b1, 3, 10, 0, -1, -1, 1'b0, 200);
      check("basic_en_len", m_en, 31);
      check("basic_rises", rise_q.size(), 3);
      check("basic_rise0", rq(0), 1);
      check("basic_rise1", rq(1), 11);
      check("basic_rise2", rq(2), 21);
      check("basic_high_total", m_high, 15);
      check("basic_done_cnt", m_done, 1);
      check("basic_done_t", m_done_t, 30);
      check_idle_after("basic", 1'b1);

      // Minimum period: high one clock, low one clock
      run_move(1'b0, 3, 2, 0, -1, -1, 1'b0, 100);
      check("p2_rises", rise_q.size(), 3);
      check("p2_rise2", rq(2), 5);
      check("p2_high_total", m_high, 3);
      check("p2_en_len", m_en, 7);
      check("p2_done_t", m_done_t, 6);
      check_idle_after("p2", 1'b0);

      // Stop at the 5th rise of a 100-step move
      run_move(1'b1, 100, 8, 5, -1, -1, 1'b0, 1000);
      check("stop_rises", rise_q.size(), 5);
      check("stop_done_cnt", m_done, 1);
      check("stop_done_t", m_done_t, 40);
      check("stop_en_len", m_en, 41);
      check_idle_after("stop", 1'b1);

      // Start and stop together in IDLE: start wins, move runs in full
      run_move(1'b0, 2, 4, 0, -1, -1, 1'b1, 100);
      check("startstop_rises", rise_q.size(), 2);
      check("startstop_rise1", rq(1), 5);
      check("startstop_en_len", m_en, 9);
      check("startstop_done_cnt", m_done, 1);

      // Second start with other direction during RUN is dropped
      run_move(1'b1, 3, 10, 0, 5, -1, 1'b0, 200);
      check("restart_dir_bad", m_dir_bad, 0);
      check("restart_rises", rise_q.size(), 3);
      check("restart_rise2", rq(2), 21);
      check("restart_en_len", m_en, 31);
      check_idle_after("restart", 1'b1);
`endif

      // Reset mid-move: outputs clear at once, no done
      run_move(1'b1, 3, 10, 0, -1, 15, 1'b0, 200);
      check("rst_no_done", m_done, 0);
      @(negedge clk);
      check("rst_held_outputs", int'({step_clk, en, busy, done, dir}), 0);
      rst = 1'b0;

`ifndef STEP_MOVE_RAMP_EN
      // Fresh move after reset behaves like the basic move
      run_move(1'b0, 3, 10, 0, -1, -1, 1'b0, 200);
      check("post_rst_en_len", m_en, 31);
      check("post_rst_rises", rise_q.size(), 3);
      check("post_rst_rise2", rq(2), 21);
      check("post_rst_done_t", m_done_t, 30);
      check_idle_after("post_rst", 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
